// File: rtl/dll_pkg.sv
// Shared DLL loop definitions: code width, SAR mid-scale reset code,
// loop-phase enum and the non-wrapping code distance helper.
package dll_pkg;

  localparam int CODE_W = 10;
  localparam logic [CODE_W-1:0] MID_CODE = {1'b1, {(CODE_W-1){1'b0}}};

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_e;

  // One extra bit so 0 vs full-scale yields full-scale, not 1.
  function automatic logic [CODE_W:0] code_delta(input logic [CODE_W-1:0] a,
                                                 input logic [CODE_W-1:0] b);
    logic signed [CODE_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d;
  endfunction

endpackage

// File: rtl/dcdl_therm_dec.sv
// Combinational binary to thermometer decoder: therm_o[i] = (bin_i > i).
module dcdl_therm_dec #(
  parameter int CW = 4
) (
  input  logic [CW-1:0]      bin_i,
  output logic [2**CW-2:0]   therm_o
);

  for (genvar i = 0; i < 2**CW-1; i++) begin : g_bit
    assign therm_o[i] = (bin_i > CW'(i));
  end

endmodule

// File: rtl/dcdl_code_ctrl.sv
// DCDL code controller: latches SAR codes, drives coarse/fine DCDL words
// two cycles later, and tracks ACQ -> TRACK -> LOCKED. Optional macro
// DCDL_HYST_EN freezes the DCDL word against small dither while locked.
module dcdl_code_ctrl
  import dll_pkg::*;
#(
  parameter int W        = CODE_W,
  parameter int CW       = 4,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 8
) (
  input  logic              clk4,
  input  logic              rst,
  input  logic [W-1:0]      code_in,
  input  logic              code_vld,
  input  logic              restart,
  output logic [2**CW-2:0]  coarse_therm,
  output logic [W-CW-1:0]   fine,
  output logic [W-1:0]      code_out,
  output logic              acq_done,
  output logic              locked
);

  localparam int TW  = 2**CW-1;
  localparam int FW  = W-CW;
  localparam int SW  = $clog2(W+1);
  localparam int CNW = 8;
  localparam logic [TW-1:0] RST_THERM = TW'((1 << (2**(CW-1))) - 1);

  logic [W-1:0]   code_q, code_out_q;
  logic [W:0]     delta_q;
  logic           vld_q, stable, upd;
  logic [TW-1:0]  therm_d, therm_q;
  logic [FW-1:0]  fine_q;
  state_e         state_q, state_d;
  logic [SW-1:0]  step_q, step_d;
  logic [CNW-1:0] stab_q, stab_d;

  // Stage 1: capture the code and its distance from the applied code.
  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      code_q  <= MID_CODE;
      delta_q <= '0;
    end else begin
      vld_q <= code_vld;
      if (code_vld) begin
        code_q  <= code_in;
        delta_q <= code_delta(code_in, code_out_q);
      end
    end
  end

  assign stable = (delta_q <= (W+1)'(TOL));

`ifdef DCDL_HYST_EN
  assign upd = vld_q && !(state_q == LOCKED && stable);
`else
  assign upd = vld_q;
`endif

  dcdl_therm_dec #(.CW(CW)) u_dec (
    .bin_i   (code_q[W-1 -: CW]),
    .therm_o (therm_d)
  );

  // Stage 2: code, thermometer and fine word move together.
  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      code_out_q <= MID_CODE;
      therm_q    <= RST_THERM;
      fine_q     <= '0;
    end else if (upd) begin
      code_out_q <= code_q;
      therm_q    <= therm_d;
      fine_q     <= code_q[FW-1:0];
    end
  end

  assign code_out     = code_out_q;
  assign coarse_therm = therm_q;
  assign fine         = fine_q;

  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      state_q <= ACQ;
      step_q  <= '0;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      stab_q  <= stab_d;
    end
  end

  // Restart overrides any stage-2 result landing in the same cycle.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    stab_d  = stab_q;
    if (restart) begin
      state_d = ACQ;
      step_d  = '0;
      stab_d  = '0;
    end else if (vld_q) begin
      case (state_q)
        ACQ: begin
          step_d = step_q + 1'b1;
          if (step_q == SW'(W-1)) begin
            state_d = TRACK;
            stab_d  = '0;
          end
        end
        TRACK: begin
          if (stable) begin
            if (stab_q != CNW'(LOCK_CNT)) stab_d = stab_q + 1'b1;
            if (stab_q >= CNW'(LOCK_CNT-1)) state_d = LOCKED;
          end else begin
            stab_d = '0;
          end
        end
        LOCKED: begin
          if (!stable) begin
            state_d = TRACK;
            stab_d  = '0;
          end
        end
        default: state_d = ACQ;
      endcase
    end
  end

  always_comb begin
    acq_done = (state_q != ACQ);
    locked   = (state_q == LOCKED);
  end

endmodule

// File: tb/tb_dcdl_code_ctrl.sv
// Self-checking bench for dcdl_code_ctrl: directed loop scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_dcdl_code_ctrl;

  localparam int W = 10, CW = 4, TOL = 1, LOCK_CNT = 8;

  logic        clk4 = 1'b0;
  logic        rst;
  logic [9:0]  code_in;
  logic        code_vld, restart;
  logic [14:0] coarse_therm;
  logic [5:0]  fine;
  logic [9:0]  code_out;
  logic        acq_done, locked;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_out, m_steps, m_stable;
  bit m_done, m_lock;
  bit p_v;
  int p_code, p_delta;

  always #5 clk4 = ~clk4;

  dcdl_code_ctrl dut (
    .clk4         (clk4),
    .rst          (rst),
    .code_in      (code_in),
    .code_vld     (code_vld),
    .restart      (restart),
    .coarse_therm (coarse_therm),
    .fine         (fine),
    .code_out     (code_out),
    .acq_done     (acq_done),
    .locked       (locked)
  );

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [14:0] exp_therm(input int c);
    int top;
    top = c >> (W - CW);
    return 15'((1 << top) - 1);
  endfunction

  function automatic void model_reset();
    m_out = 512; m_steps = 0; m_stable = 0;
    m_done = 0; m_lock = 0; p_v = 0; p_code = 0; p_delta = 0;
  endfunction

  // One clock edge: a strobe is measured against the code applied right now
  // and reaches the DCDL one edge later.
  function automatic void model_edge(input bit v, input int c, input bit r);
    int  nd;
    bit  freeze;
    nd = iabs(c - m_out);
    if (p_v) begin
      freeze = 0;
`ifdef DCDL_HYST_EN
      freeze = m_lock && (p_delta <= TOL);
`endif
      if (!freeze) m_out = p_code;
      if (!r) begin
        if (!m_done) begin
          m_steps++;
          if (m_steps == W) m_done = 1;
        end else if (!m_lock) begin
          if (p_delta <= TOL) begin
            if (m_stable < LOCK_CNT) m_stable++;
            if (m_stable == LOCK_CNT) m_lock = 1;
          end else m_stable = 0;
        end else if (p_delta > TOL) begin
          m_lock = 0; m_stable = 0;
        end
      end
    end
    if (r) begin
      m_done = 0; m_lock = 0; m_steps = 0; m_stable = 0;
    end
    p_v = v; p_code = c; p_delta = nd;
  endfunction

  task automatic cyc(input bit v, input int c, input bit r);
    code_vld = v; code_in = 10'(c); restart = r;
    @(posedge clk4);
    model_edge(v, c, r);
    @(negedge clk4);
    code_vld = 1'b0; restart = 1'b0;
  endtask

  task automatic strobe(input int c);
    cyc(1'b1, c, 1'b0);
    cyc(1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; code_vld = 1'b0; restart = 1'b0; code_in = '0;
    model_reset();
    repeat (3) @(negedge clk4);
    if (code_out !== 10'd512 || coarse_therm !== 15'h00FF || fine !== 6'd0 ||
        acq_done !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_in got out=%0d therm=%h fine=%0d ad=%b lk=%b exp 512/00ff/0/0/0",
               code_out, coarse_therm, fine, acq_done, locked);
    end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 0, 1'b0);
      if (code_out !== 10'd512 || coarse_therm !== 15'h00FF || fine !== 6'd0 ||
          acq_done !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got out=%0d therm=%h fine=%0d ad=%b lk=%b",
                 i, code_out, coarse_therm, fine, acq_done, locked);
      end
      checks++;
    end
  endtask

  task automatic test_acq();
    int codes[10] = '{768, 640, 704, 672, 688, 680, 684, 686, 685, 685};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, codes[i], 1'b0);
      if (acq_done !== 1'b0) begin
        errors++;
        $display("FAIL acq_early step=%0d got acq_done=%b exp 0", i, acq_done);
      end
      checks++;
      cyc(1'b0, 0, 1'b0);
      if (code_out !== 10'(codes[i])) begin
        errors++;
        $display("FAIL acq_code step=%0d got %0d exp %0d", i, code_out, codes[i]);
      end
      checks++;
    end
    if (acq_done !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL acq_done got ad=%b lk=%b exp ad=1 lk=0", acq_done, locked);
    end
    checks++;
    if (coarse_therm !== 15'h03FF || fine !== 6'h2D) begin
      errors++;
      $display("FAIL acq_split got therm=%h fine=%h exp 03ff/2d", coarse_therm, fine);
    end
    checks++;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 8; i++) begin
      strobe((i % 2 == 0) ? 685 : 686);
      if (locked !== ((i == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL lock_acquire n=%0d got %b exp %b", i + 1, locked, i == 7);
      end
      checks++;
    end
    cyc(1'b1, 690, 1'b0);
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_drop_early got %b exp 1", locked);
    end
    checks++;
    cyc(1'b0, 0, 1'b0);
    if (locked !== 1'b0 || code_out !== 10'd690) begin
      errors++;
      $display("FAIL lock_drop got lk=%b out=%0d exp 0/690", locked, code_out);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      strobe((i % 2 == 0) ? 691 : 690);
      if (locked !== ((i == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL lock_reacq n=%0d got %b exp %b", i + 1, locked, i == 7);
      end
      checks++;
    end
  endtask

  task automatic test_restart();
    cyc(1'b1, 300, 1'b1);
    if (locked !== 1'b0 || acq_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_flags got lk=%b ad=%b exp 0/0", locked, acq_done);
    end
    checks++;
    cyc(1'b0, 0, 1'b0);
    if (code_out !== 10'd300 || acq_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_code got out=%0d ad=%b exp 300/0", code_out, acq_done);
    end
    checks++;
    for (int i = 0; i < 9; i++) begin
      strobe(300 + i);
      if (acq_done !== ((i == 8) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL restart_steps n=%0d got %b exp %b", i + 1, acq_done, i == 8);
      end
      checks++;
    end
  endtask

  task automatic test_boundary();
    strobe(0);
    if (code_out !== 10'd0 || coarse_therm !== 15'h0000 || fine !== 6'h00) begin
      errors++;
      $display("FAIL bnd_zero got out=%0d therm=%h fine=%h exp 0/0000/00",
               code_out, coarse_therm, fine);
    end
    checks++;
    for (int i = 0; i < 6; i++) strobe(0);
    strobe(1023);
    if (code_out !== 10'd1023 || coarse_therm !== 15'h7FFF || fine !== 6'h3F ||
        locked !== 1'b0) begin
      errors++;
      $display("FAIL bnd_full got out=%0d therm=%h fine=%h lk=%b exp 1023/7fff/3f/0",
               code_out, coarse_therm, fine, locked);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      strobe(1023);
      if (locked !== ((i == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bnd_nowrap n=%0d got %b exp %b", i + 1, locked, i == 7);
      end
      checks++;
    end
  endtask

  task automatic test_hyst();
    for (int i = 0; i < 9; i++) strobe(685);
    if (locked !== 1'b1 || code_out !== 10'd685) begin
      errors++;
      $display("FAIL hyst_setup got lk=%b out=%0d exp 1/685", locked, code_out);
    end
    checks++;
    strobe(686);
`ifdef DCDL_HYST_EN
    if (code_out !== 10'd685 || locked !== 1'b1) begin
      errors++;
      $display("FAIL hyst_dither got out=%0d lk=%b exp 685/1", code_out, locked);
    end
`else
    if (code_out !== 10'd686 || locked !== 1'b1) begin
      errors++;
      $display("FAIL hyst_dither got out=%0d lk=%b exp 686/1", code_out, locked);
    end
`endif
    checks++;
    strobe(688);
    if (code_out !== 10'd688 || locked !== 1'b0 || fine !== 6'h30) begin
      errors++;
      $display("FAIL hyst_jump got out=%0d lk=%b fine=%h exp 688/0/30",
               code_out, locked, fine);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int seq[3] = '{100, 200, 300};
    cyc(1'b1, seq[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(1'b1, seq[i+1], 1'b0);
      else       cyc(1'b0, 0, 1'b0);
      if (code_out !== 10'(seq[i]) || coarse_therm !== exp_therm(seq[i])) begin
        errors++;
        $display("FAIL b2b n=%0d got out=%0d therm=%h exp %0d/%h",
                 i, code_out, coarse_therm, seq[i], exp_therm(seq[i]));
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int cur;
    bit v, r;
    int c;
    cur = 500;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(99) < 60);
      r = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 10) cur = int'($urandom_range(1023));
      else cur = cur + int'($urandom_range(2)) - 1;
      if (cur < 0) cur = 0;
      if (cur > 1023) cur = 1023;
      c = cur;
      cyc(v, c, r);
      if (code_out !== 10'(m_out) || coarse_therm !== exp_therm(m_out) ||
          fine !== 6'(m_out & 63) || acq_done !== m_done || locked !== m_lock) begin
        errors++;
        $display("FAIL rand n=%0d got out=%0d therm=%h fine=%h ad=%b lk=%b exp %0d/%h/%h/%b/%b",
                 n, code_out, coarse_therm, fine, acq_done, locked,
                 m_out, exp_therm(m_out), 6'(m_out & 63), m_done, m_lock);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_acq();
    test_lock();
    test_restart();
    test_boundary();
    test_hyst();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
